// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: data/CSR/structural hazards and trap redirects.
// Optional feature macro: FORWARD_EN (EX/MEM->D bypass; only load-use in EX stalls).
module pipe_hazard_ctrl #(
    parameter int PC_W   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use1,
    input  logic              dec_use2,
    input  logic              dec_is_csr,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              ex_busy,
    input  logic              mem_busy,
    input  logic              ex_redirect,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              trap_valid,
    input  logic [PC_W-1:0]   trap_pc,
    output logic              stall_f,
    output logic              stall_d,
    output logic              freeze,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    // state     | meaning
    // RUN       | normal issue, hazards resolved per cycle
    // CSR_WAIT  | CSR held in decode until EX/MEM/WB are empty
    // TRAP_WAIT | trap pending, MEM draining an outstanding dmem transaction
    // TRAP      | one-cycle redirect to the latched trap target
    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_CSR_WAIT  = 2'd1,
        S_TRAP_WAIT = 2'd2,
        S_TRAP      = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PC_W-1:0] trap_pc_q;

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;
    logic data_hazard;
    logic structural;
    logic pipe_busy;

    function automatic logic src_match(input logic [REG_AW-1:0] dst);
        return (dec_use1 && (dec_rs1 != '0) && (dec_rs1 == dst)) ||
               (dec_use2 && (dec_rs2 != '0) && (dec_rs2 == dst));
    endfunction

    assign hit_ex  = ex_valid  && ex_wen  && src_match(ex_dst);
    assign hit_mem = mem_valid && mem_wen && src_match(mem_dst);
    assign hit_wb  = wb_valid  && wb_wen  && src_match(wb_dst);

`ifdef FORWARD_EN
    // Bypass covers everything except a load still in EX.
    assign data_hazard = dec_valid && hit_ex && ex_is_load;
`else
    assign data_hazard = dec_valid && (hit_ex || hit_mem || hit_wb);
`endif

    assign structural = ex_busy || mem_busy;
    assign pipe_busy  = ex_valid || mem_valid || wb_valid;

    always_comb begin
        state_n        = state;
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        freeze         = 1'b0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;
        flush_m        = 1'b0;
        flush_w        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        if (reset) begin
            // Outputs stay quiet during reset even if the state register is mid-trap.
            state_n = S_RUN;
        end else if (trap_valid) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
            state_n = mem_busy ? S_TRAP_WAIT : S_TRAP;
        end else begin
            case (state)
                S_TRAP_WAIT: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    flush_w = 1'b1;
                    if (!mem_busy) state_n = S_TRAP;
                end
                S_TRAP: begin
                    flush_d        = 1'b1;
                    flush_e        = 1'b1;
                    flush_m        = 1'b1;
                    flush_w        = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = trap_pc_q;
                    state_n        = S_RUN;
                end
                default: begin
                    if (structural) begin
                        // EX keeps any pending redirect and re-presents it after the freeze.
                        freeze  = 1'b1;
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                    end else if (ex_redirect) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        flush_d        = 1'b1;
                        flush_e        = 1'b1;
                        state_n        = S_RUN;
                    end else if (state == S_CSR_WAIT) begin
                        if (pipe_busy) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            flush_e = 1'b1;
                        end else begin
                            state_n = S_RUN;
                        end
                    end else if (dec_valid && dec_is_csr && pipe_busy) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        state_n = S_CSR_WAIT;
                    end else if (data_hazard) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            trap_pc_q <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (trap_valid) trap_pc_q <= trap_pc;
            if (stall_d && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expectations adapt to FORWARD_EN.
module tb_pipe_hazard_ctrl;

    localparam int PC_W   = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              dec_valid, dec_use1, dec_use2, dec_is_csr;
    logic [REG_AW-1:0] dec_rs1, dec_rs2;
    logic              ex_valid, ex_wen, ex_is_load;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_valid, mem_wen;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_valid, wb_wen;
    logic [REG_AW-1:0] wb_dst;
    logic              ex_busy, mem_busy, ex_redirect, trap_valid;
    logic [PC_W-1:0]   ex_target, trap_pc;
    logic              stall_f, stall_d, freeze, flush_d, flush_e, flush_m, flush_w;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic [7:0]       ctl;

    // {stall_f, stall_d, freeze, flush_d, flush_e, flush_m, flush_w, redirect_valid}
    assign ctl = {stall_f, stall_d, freeze, flush_d, flush_e, flush_m, flush_w, redirect_valid};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_is_csr(dec_is_csr),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_dst(mem_dst),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst),
        .ex_busy(ex_busy), .mem_busy(mem_busy),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .stall_f(stall_f), .stall_d(stall_d), .freeze(freeze),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt)
    );

    task automatic drive_idle();
        dec_valid = 0; dec_use1 = 0; dec_use2 = 0; dec_is_csr = 0;
        dec_rs1 = '0; dec_rs2 = '0;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_dst = '0;
        mem_valid = 0; mem_wen = 0; mem_dst = '0;
        wb_valid = 0; wb_wen = 0; wb_dst = '0;
        ex_busy = 0; mem_busy = 0; ex_redirect = 0; ex_target = '0;
        trap_valid = 0; trap_pc = '0;
    endtask

    // add x6, x5, x1 in decode
    task automatic drive_dec_add();
        dec_valid = 1; dec_use1 = 1; dec_use2 = 1; dec_rs1 = 5'd5; dec_rs2 = 5'd1;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_idle();
            drive_dec_add();
            ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd5;
            ex_redirect = 1; ex_target = 64'h1000;
            #1;
            n_checks++;
            if (ctl !== 8'b0 || redirect_pc !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: ctl=%b pc=%h, required ctl=00000000 pc=0", c, ctl, redirect_pc);
            end
        end
        @(negedge clk);
        reset = 0;
        drive_idle();
        #1;
        n_checks++;
        if (stall_cnt !== '0 || ctl !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: stall_cnt=%0d ctl=%b, required 0 / 00000000", stall_cnt, ctl);
        end
        exp_cnt = '0;
    endtask

    task automatic test_data_hazard();
        logic [7:0] exp_mw;
`ifdef FORWARD_EN
        exp_mw = 8'b0000_0000;
`else
        exp_mw = 8'b1100_1000;
`endif
        @(negedge clk);
        drive_idle(); drive_dec_add();
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd5;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL hazard_ex_load: ctl=%b, required 11001000", ctl);
        end
        exp_cnt = exp_cnt + 1;

        @(negedge clk);
        drive_idle(); drive_dec_add();
        mem_valid = 1; mem_wen = 1; mem_dst = 5'd5;
        #1;
        n_checks++;
        if (ctl !== exp_mw) begin
            n_fail++; $display("FAIL hazard_mem: ctl=%b, required %b", ctl, exp_mw);
        end
        if (exp_mw[6]) exp_cnt = exp_cnt + 1;

        @(negedge clk);
        drive_idle(); drive_dec_add();
        wb_valid = 1; wb_wen = 1; wb_dst = 5'd5;
        #1;
        n_checks++;
        if (ctl !== exp_mw) begin
            n_fail++; $display("FAIL hazard_wb: ctl=%b, required %b", ctl, exp_mw);
        end
        if (exp_mw[6]) exp_cnt = exp_cnt + 1;

        @(negedge clk);
        drive_idle(); drive_dec_add();
        #1;
        n_checks++;
        if (ctl !== 8'b0) begin
            n_fail++; $display("FAIL hazard_clear: ctl=%b, required 00000000", ctl);
        end

        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL hazard_stall_cnt: got %0d, required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_no_hazard_cases();
        // rs == x0 never hazards
        @(negedge clk);
        drive_idle();
        dec_valid = 1; dec_use1 = 1; dec_rs1 = 5'd0;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd0;
        #1;
        n_checks++;
        if (ctl !== 8'b0) begin
            n_fail++; $display("FAIL x0_no_hazard: ctl=%b, required 00000000", ctl);
        end
        // match on an unused source, or a non-writing producer, never hazards
        @(negedge clk);
        drive_idle();
        dec_valid = 1; dec_use1 = 0; dec_use2 = 1; dec_rs1 = 5'd7; dec_rs2 = 5'd3;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd7;
        mem_valid = 1; mem_wen = 0; mem_dst = 5'd3;
        #1;
        n_checks++;
        if (ctl !== 8'b0) begin
            n_fail++; $display("FAIL unused_src_no_hazard: ctl=%b, required 00000000", ctl);
        end
        // rs2 path stalls on a load in EX
        @(negedge clk);
        drive_idle();
        dec_valid = 1; dec_use2 = 1; dec_rs2 = 5'd9;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd9;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL rs2_hazard: ctl=%b, required 11001000", ctl);
        end
        exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_redirect_priority();
        @(negedge clk);
        drive_idle(); drive_dec_add();
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd5;
        ex_redirect = 1; ex_target = 64'h0000_0000_8000_0040;
        #1;
        n_checks++;
        if (ctl !== 8'b0001_1001 || redirect_pc !== 64'h0000_0000_8000_0040) begin
            n_fail++;
            $display("FAIL redirect_beats_hazard: ctl=%b pc=%h, required 00011001 pc=80000040", ctl, redirect_pc);
        end
    endtask

    task automatic test_csr();
        @(negedge clk);
        drive_idle();
        dec_valid = 1; dec_is_csr = 1; ex_valid = 1; mem_valid = 1;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL csr_enter: ctl=%b, required 11001000", ctl);
        end
        exp_cnt = exp_cnt + 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_idle();
            dec_valid = 1; dec_is_csr = 1;
            if (c == 0) begin mem_valid = 1; wb_valid = 1; end
            else wb_valid = 1;
            #1;
            n_checks++;
            if (ctl !== 8'b1100_1000) begin
                n_fail++; $display("FAIL csr_wait cycle %0d: ctl=%b, required 11001000", c, ctl);
            end
            exp_cnt = exp_cnt + 1;
        end
        @(negedge clk);
        drive_idle();
        dec_valid = 1; dec_is_csr = 1;
        #1;
        n_checks++;
        if (ctl !== 8'b0) begin
            n_fail++; $display("FAIL csr_release: ctl=%b, required 00000000", ctl);
        end
        // back in RUN: a plain data hazard still acts normally
        @(negedge clk);
        drive_idle(); drive_dec_add();
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 5'd1;
        #1;
        n_checks++;
        if (ctl !== 8'b1100_1000) begin
            n_fail++; $display("FAIL csr_back_to_run: ctl=%b, required 11001000", ctl);
        end
        exp_cnt = exp_cnt + 1;
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL csr_stall_cnt: got %0d, required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_trap_wait();
        @(negedge clk);
        drive_idle();
        trap_valid = 1; trap_pc = 64'h0000_0000_8000_0100; mem_busy = 1;
        #1;
        n_checks++;
        if (ctl !== 8'b1001_1010) begin
            n_fail++; $display("FAIL trap_accept: ctl=%b, required 10011010", ctl);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_idle();
            trap_pc = 64'hDEAD_BEEF_0000_0000;
            mem_busy = (c < 2);
            ex_redirect = 1; ex_target = 64'h5555;
            #1;
            n_checks++;
            if (ctl !== 8'b1001_1010) begin
                n_fail++; $display("FAIL trap_wait cycle %0d: ctl=%b, required 10011010", c, ctl);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (ctl !== 8'b0001_1111 || redirect_pc !== 64'h0000_0000_8000_0100) begin
            n_fail++;
            $display("FAIL trap_redirect: ctl=%b pc=%h, required 00011111 pc=80000100", ctl, redirect_pc);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (ctl !== 8'b0 || stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL trap_done: ctl=%b cnt=%0d, required 00000000 cnt=%0d", ctl, stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_trap_latency();
        @(negedge clk);
        drive_idle();
        trap_valid = 1; trap_pc = 64'h0000_0000_0000_2000;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL trap_lat_cycle0: redirect_valid=%b, required 0", redirect_valid);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (ctl !== 8'b0001_1111 || redirect_pc !== 64'h0000_0000_0000_2000) begin
            n_fail++;
            $display("FAIL trap_lat_cycle1: ctl=%b pc=%h, required 00011111 pc=2000", ctl, redirect_pc);
        end
    endtask

    task automatic test_struct_redirect();
        @(negedge clk);
        drive_idle();
        mem_busy = 1; ex_redirect = 1; ex_target = 64'h0000_0000_0000_1234;
        #1;
        n_checks++;
        if (ctl !== 8'b1110_0000) begin
            n_fail++; $display("FAIL struct_freeze: ctl=%b, required 11100000", ctl);
        end
        exp_cnt = exp_cnt + 1;
        @(negedge clk);
        mem_busy = 0; ex_busy = 0;
        #1;
        n_checks++;
        if (ctl !== 8'b0001_1001 || redirect_pc !== 64'h0000_0000_0000_1234) begin
            n_fail++;
            $display("FAIL struct_release_redirect: ctl=%b pc=%h, required 00011001 pc=1234", ctl, redirect_pc);
        end
        @(negedge clk);
        drive_idle();
        ex_busy = 1;
        #1;
        n_checks++;
        if (ctl !== 8'b1110_0000) begin
            n_fail++; $display("FAIL ex_busy_freeze: ctl=%b, required 11100000", ctl);
        end
        exp_cnt = exp_cnt + 1;
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL struct_stall_cnt: got %0d, required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_trap();
        @(negedge clk);
        drive_idle();
        trap_valid = 1; trap_pc = 64'h0000_0000_0000_3000;
        @(negedge clk);
        drive_idle();
        reset = 1;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0 || ctl !== 8'b0) begin
            n_fail++; $display("FAIL reset_mid_trap: ctl=%b, required 00000000", ctl);
        end
        @(negedge clk);
        reset = 0;
        #1;
        n_checks++;
        if (ctl !== 8'b0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL after_reset_mid_trap: ctl=%b cnt=%0d, required 00000000 cnt=0", ctl, stall_cnt);
        end
        exp_cnt = '0;
    endtask

    initial begin
        drive_idle();
        exp_cnt = '0;
        test_reset();
        test_data_hazard();
        test_no_hazard_cases();
        test_redirect_priority();
        test_csr();
        test_trap_wait();
        test_trap_latency();
        test_struct_redirect();
        test_reset_mid_trap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
